hp_tracker: RTL and testbench

Damage/health stage directly downstream of the player-bullet logic. Consumes the one-cycle hit pulse produced when a bullet overlaps the target, applies damage (reduced while the target defends), and enforces an invulnerability window after each accepted hit. It drives the health value, blink flag and dead flag used by the HUD/renderer and the round controller.

---
 rtl/hp_tracker.sv | 101 ++++++++++
 tb/tb_hp_tracker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hp_tracker.sv
// hp_tracker: health/damage stage with post-hit invulnerability window.
// Optional HP_REGEN_EN adds slow health regeneration while ALIVE.
module hp_tracker #(
  parameter int MAX_HP        = 8,
  parameter int HP_W          = 4,
  parameter int HIT_DAMAGE    = 2,
  parameter int GUARD_DAMAGE  = 1,
  parameter int IFRAME_FRAMES = 30,
  parameter int REGEN_FRAMES  = 120
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            round_start,
  input  logic            hit,
  input  logic            defend,
  output logic [HP_W-1:0] hp,
  output logic            blink,
  output logic            dead,
  output logic            hit_taken
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIVE = 2'd1;
  localparam logic [1:0] STUN  = 2'd2;
  localparam logic [1:0] DEAD  = 2'd3;
  // blink taps bit 2, so the counter is never narrower than 3 bits
  localparam int CW = ($clog2(IFRAME_FRAMES + 1) < 3) ? 3 : $clog2(IFRAME_FRAMES + 1);

  if (MAX_HP >= 2 ** HP_W || IFRAME_FRAMES < 1 || REGEN_FRAMES < 1) begin : g_bad_params
    $error("hp_tracker: invalid parameters");
  end

  logic [1:0]      st, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [HP_W-1:0] hp_n, dmg;
  logic            take;

  assign dmg = defend ? HP_W'(GUARD_DAMAGE) : HP_W'(HIT_DAMAGE);

`ifdef HP_REGEN_EN
  localparam int RW = $clog2(REGEN_FRAMES + 1);
  logic [RW-1:0] rc, rc_n;
  logic          rc_full;
  assign rc_full = rc == RW'(REGEN_FRAMES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rc <= '0;
    else rc <= rc_n;
`endif

  always_comb begin
    st_n = st;
    hp_n = hp;
    cnt_n = cnt;
    take = 1'b0;
`ifdef HP_REGEN_EN
    rc_n = rc;
`endif
    if (round_start) begin
      st_n = ALIVE;
      hp_n = HP_W'(MAX_HP);
      cnt_n = '0;
`ifdef HP_REGEN_EN
      rc_n = '0;
`endif
    end else if (st == ALIVE && hit) begin
      take = 1'b1;
      hp_n = (hp <= dmg) ? '0 : hp - dmg;
      st_n = (hp_n == '0) ? DEAD : STUN;
      cnt_n = (hp_n == '0) ? '0 : CW'(IFRAME_FRAMES);
`ifdef HP_REGEN_EN
      rc_n = '0;
`endif
    end else if (st == STUN && frame_tick) begin
      st_n = (cnt <= CW'(1)) ? ALIVE : STUN;
      cnt_n = (cnt <= CW'(1)) ? '0 : cnt - CW'(1);
    end
`ifdef HP_REGEN_EN
    else if (st == ALIVE && frame_tick) begin
      rc_n = rc_full ? '0 : rc + RW'(1);
      hp_n = (rc_full && hp < HP_W'(MAX_HP)) ? hp + HP_W'(1) : hp;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      hp <= HP_W'(MAX_HP);
      blink <= 1'b0;
      dead <= 1'b0;
      hit_taken <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      hp <= hp_n;
      blink <= (st_n == STUN) && cnt_n[2];
      dead <= st_n == DEAD;
      hit_taken <= take;
    end
endmodule

// File: tb/tb_hp_tracker.sv
// tb_hp_tracker: directed self-checking bench for hp_tracker (default parameters).
module tb_hp_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       round_start = 1'b0;
  logic       hit = 1'b0;
  logic       defend = 1'b0;
  logic [3:0] hp;
  logic       blink, dead, hit_taken;
  int         checks = 0;
  int         failures = 0;

  hp_tracker dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_start(round_start),
    .hit(hit), .defend(defend), .hp(hp), .blink(blink), .dead(dead), .hit_taken(hit_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic d, input logic f);
    round_start = r;
    hit = h;
    defend = d;
    frame_tick = f;
    @(posedge clk);
    #1;
    round_start = 1'b0;
    hit = 1'b0;
    defend = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    #23;
    chk("reset_hp", hp, 8);
    chk("reset_dead", dead, 0);
    chk("reset_blink", blink, 0);
    chk("reset_taken", hit_taken, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    chk("idle_hit_hp", hp, 8);
    chk("idle_hit_taken", hit_taken, 0);
    step(1, 0, 0, 0);
    chk("start_hp", hp, 8);
    chk("start_dead", dead, 0);
    chk("start_blink", blink, 0);
    step(0, 1, 0, 0);
    chk("hit1_hp", hp, 6);
    chk("hit1_taken", hit_taken, 1);
    chk("hit1_blink", blink, 1);
    step(0, 0, 0, 0);
    chk("hit1_pulse_width", hit_taken, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("stun_hit_hp", hp, 6);
    chk("stun_hit_taken", hit_taken, 0);
    // counter goes 30 -> 1 over 29 ticks; blink follows bit 2
    for (int k = 1; k <= 28; k++) begin
      step(0, 0, 0, 1);
      chk("stun_blink", blink, ((30 - k) >> 2) & 1);
    end
    step(0, 1, 0, 1);
    chk("tick29_hit_hp", hp, 6);
    chk("tick29_blink", blink, 0);
    step(0, 0, 0, 1);
    chk("tick30_blink", blink, 0);
    step(0, 1, 1, 1);
    chk("guard_hp", hp, 5);
    chk("guard_taken", hit_taken, 1);
    ticks(2);
    chk("hit_tick_no_dec_blink", blink, 1);
    ticks(28);
    step(0, 1, 0, 0);
    chk("hp3", hp, 3);
    ticks(30);
    step(0, 1, 0, 0);
    chk("hp1", hp, 1);
    ticks(30);
    step(0, 1, 0, 0);
    chk("kill_hp", hp, 0);
    chk("kill_dead", dead, 1);
    chk("kill_taken", hit_taken, 1);
    chk("kill_blink", blink, 0);
    ticks(3);
    step(0, 1, 0, 0);
    chk("dead_hit_hp", hp, 0);
    chk("dead_hit_taken", hit_taken, 0);
    chk("dead_hold", dead, 1);
    step(1, 0, 0, 0);
    chk("restart_hp", hp, 8);
    chk("restart_dead", dead, 0);
    step(0, 1, 0, 0);
    ticks(30);
    step(0, 1, 0, 0);
    chk("hp4", hp, 4);
    ticks(30);
    step(1, 1, 0, 0);
    chk("start_hit_hp", hp, 8);
    chk("start_hit_taken", hit_taken, 0);
    chk("start_hit_blink", blink, 0);
    step(0, 1, 1, 0);
    chk("after_start_alive_hp", hp, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_hp", hp, 8);
    chk("async_reset_blink", blink, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    chk("post_reset_idle_hp", hp, 8);
`ifdef HP_REGEN_EN
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(30);
    ticks(119);
    chk("regen_119_hp", hp, 6);
    step(0, 0, 0, 1);
    chk("regen_120_hp", hp, 7);
    ticks(120);
    chk("regen_240_hp", hp, 8);
    ticks(120);
    chk("regen_sat_hp", hp, 8);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
